// File: rtl/dac_serial_writer.sv
// Serial DAC transmitter: shifts {00, pd, level, 0000} out on a 3-wire
// nSYNC/SCLK/DIN link (DAC081S101-style) with a one-deep request buffer.
module dac_serial_writer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] level,
  input  logic [1:0] pd,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       nSYNC,
  output logic       SCLK,
  output logic       DIN
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned REQ_W   = 10;

  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     hp_cnt_q, hp_cnt_d;
  logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [REQ_W-1:0]     pend_data_q, pend_data_d;
  logic                 nsync_q, nsync_d;
  logic                 sclk_q, sclk_d;
  logic                 din_q, din_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 load;
  logic [REQ_W-1:0]     load_req;
  logic [FRAME_W-1:0]   load_frame;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    hp_cnt_d     = hp_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    nsync_d      = nsync_q;
    sclk_d       = sclk_q;
    din_d        = din_q;
    load         = 1'b0;
    load_req     = '0;
    load_frame   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          load_req = {pd, level};
        end
      end

      SHIFT: begin
        if (start) begin
          pend_valid_d = 1'b1;
          pend_data_d  = {pd, level};
        end
        if (hp_cnt_q == HP_LAST) begin
          hp_cnt_d = '0;
          if (sclk_q) begin
            // end of high phase: falling edge, DAC samples DIN
            sclk_d = 1'b0;
          end else if (bit_q == '0) begin
            // end of low phase of the last bit: close the frame
            state_d   = GAP;
            nsync_d   = 1'b1;
            sclk_d    = 1'b1;
            din_d     = 1'b0;
            gap_cnt_d = '0;
          end else begin
            // rising edge: present the next bit
            sclk_d  = 1'b1;
            bit_d   = bit_q - 4'd1;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            din_d   = shreg_q[FRAME_W-2];
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 8'd1;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (start) begin
            load         = 1'b1;
            load_req     = {pd, level};
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            load         = 1'b1;
            load_req     = pend_data_q;
            pend_valid_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
          if (start) begin
            pend_valid_d = 1'b1;
            pend_data_d  = {pd, level};
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Start a new frame from a direct or buffered request
    if (load) begin
      load_frame = {2'b00, load_req, 4'b0000};
      state_d    = SHIFT;
      shreg_d    = load_frame;
      din_d      = load_frame[FRAME_W-1];
      nsync_d    = 1'b0;
      sclk_d     = 1'b1;
      hp_cnt_d   = '0;
      gap_cnt_d  = '0;
      bit_d      = 4'd15;
    end

    done_d  = (state_d == GAP) && (gap_cnt_d == GAP_LAST);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) && !pend_valid_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      hp_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      nsync_q      <= 1'b1;
      sclk_q       <= 1'b1;
      din_q        <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_cnt_q     <= hp_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      nsync_q      <= nsync_d;
      sclk_q       <= sclk_d;
      din_q        <= din_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign nSYNC = nsync_q;
  assign SCLK  = sclk_q;
  assign DIN   = din_q;

endmodule
